sha2_round_engine: RTL
======================

// Module: sha2_round_engine
// PURPOSE
//   Iterative SHA-2 compression core: loads eight working words a..h, applies one round per accepted
//   K+W word (Sigma0/Sigma1, Ch, Maj), then emits feed-forward state H+{a..h} after ROUNDS rounds.
//   Parametrised successor to the combinational Maj stage; serves SHA-256 (32b) and SHA-512 (64b).
//   Sits between the message-schedule unit (supplies K[t]+W[t]) and the hash-state register bank.
// PARAMETERS
//   DATA_WIDTH  64  word width; only 32 (SHA-256) or 64 (SHA-512) legal, else elaboration error
//   ROUNDS      80  rounds per block (64 for SHA-256); >=1
// PORTS
//   clk         in   1             single clock, all logic rising-edge
//   rst         in   1             synchronous, active-high reset
//   init_valid  in   1             init_state valid
//   init_ready  out  1             engine can accept a new block (IDLE)
//   init_state  in   8*DATA_WIDTH  {a,b,c,d,e,f,g,h}; a in MSBs, h in LSBs
//   kw_valid    in   1             kw_data valid
//   kw_ready    out  1             engine accepts a round word (ROUND)
//   kw_data     in   DATA_WIDTH    precomputed K[t]+W[t] mod 2^DATA_WIDTH
//   out_valid   out  1             out_state valid (DONE)
//   out_ready   in   1             downstream accepts out_state
//   out_state   out  8*DATA_WIDTH  {H0..H7}, same packing as init_state
//   busy        out  1             high in ROUND or DONE
// BEHAVIOUR
// - Reset (rst=1 at clk edge): state=IDLE, round_cnt=0, working and H regs=0, out_state=0,
//   out_valid=0, kw_ready=0, init_ready=1 on the first cycle after reset, busy=0.
//   rst wins over every other input; reset mid-ROUND/DONE drops the block, no output produced.
// - Handshakes: transfer when valid&&ready at clk edge. ready outputs are pure functions of state
//   (no combinational valid->ready path). Upstream holds data stable while valid&&!ready.
// - FSM states IDLE, ROUND, DONE:
//   IDLE : init_ready=1. On init transfer: working<=init_state, H<=init_state, round_cnt<=0 -> ROUND.
//   ROUND: kw_ready=1. On kw transfer apply one round; round_cnt++. No transfer -> regs unchanged.
//          Transfer with round_cnt==ROUNDS-1: out_state<=H + post-round working (wordwise) -> DONE.
//   DONE : out_valid=1, out_state held stable. On out transfer -> IDLE (init_ready high next cycle).
//   Inputs presented in the wrong state are ignored (ready low); no new block overlaps a pending one.
// - Round (all sums mod 2^DATA_WIDTH, carries discarded):
//   T1 = h + S1(e) + Ch(e,f,g) + kw_data;  T2 = S0(a) + Maj(a,b,c)
//   Ch = (e&f)^(~e&g);  Maj = (a&b)^(a&c)^(b&c)
//   h<=g g<=f f<=e e<=d+T1 d<=c c<=b b<=a a<=T1+T2
//   DATA_WIDTH=32: S0=ROTR2^ROTR13^ROTR22,  S1=ROTR6^ROTR11^ROTR25
//   DATA_WIDTH=64: S0=ROTR28^ROTR34^ROTR39, S1=ROTR14^ROTR18^ROTR41
// - Latency: init accept -> out_valid = ROUNDS cycles minimum (one kw per cycle, no stalls);
//   each kw stall cycle adds one. Throughput 1 block per ROUNDS+2 cycles with ready sinks.
// - round_cnt width $clog2(ROUNDS)+1; never exceeds ROUNDS-1 in ROUND.
// - kw_ready drops the cycle after the final round word; extra kw_valid is not consumed.
// TESTING
// 1. W=32,R=64: init=SHA-256 IV (6a09e667..5be0cd19), 64 K+W words of padded "abc" ->
//    out_state=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, 64 cycles.
// 2. W=64,R=80: SHA-512 IV, K+W of padded "abc" -> out_state=ddaf35a193617aba...a54ca49f
//    (full 512b FIPS 180-4 vector), out_valid exactly 80 cycles after init accept.
// 3. Same as 1 with kw_valid low on random 30% of cycles -> identical digest; state frozen on stalls.
// 4. out_ready low 10 cycles in DONE -> out_valid stays 1, out_state bit-stable, init_ready=0;
//    out_ready=1 -> IDLE next cycle.
// 5. rst asserted after 20 rounds -> next cycle IDLE, out_valid=0, out_state=0; new "abc" block
//    then yields the correct digest.
// 6. W=32,R=4, init=all-zero, kw=0,0,0,0 -> matches reference-model output; kw_ready low after 4th.

Source files
------------

// File: rtl/sha2_round_engine.sv
// sha2_round_engine: iterative SHA-256 / SHA-512 compression rounds.
// One round per accepted K+W word; emits H + working state at the end.
module sha2_round_engine #(
   parameter int DATA_WIDTH = 64,
   parameter int ROUNDS     = 80
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_valid,
   output logic                    init_ready,
   input  logic [8*DATA_WIDTH-1:0] init_state,
   input  logic                    kw_valid,
   output logic                    kw_ready,
   input  logic [DATA_WIDTH-1:0]   kw_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*DATA_WIDTH-1:0] out_state,
   output logic                    busy
);

   localparam int W   = DATA_WIDTH;
   localparam int CW  = $clog2(ROUNDS) + 1;
   localparam int S0A = (W == 32) ? 2  : 28;
   localparam int S0B = (W == 32) ? 13 : 34;
   localparam int S0C = (W == 32) ? 22 : 39;
   localparam int S1A = (W == 32) ? 6  : 14;
   localparam int S1B = (W == 32) ? 11 : 18;
   localparam int S1C = (W == 32) ? 25 : 41;

   generate
      if (W != 32 && W != 64) begin : g_bad_width
         $error("sha2_round_engine: DATA_WIDTH must be 32 or 64");
      end
      if (ROUNDS < 1) begin : g_bad_rounds
         $error("sha2_round_engine: ROUNDS must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [7:0][W-1:0]  wk_q;
   logic [7:0][W-1:0]  hs_q;
   logic [8*W-1:0]     out_q;
   logic [CW-1:0]      cnt_q;

   logic [7:0][W-1:0]  wk_nxt;
   logic [7:0][W-1:0]  fb;
   logic [W-1:0]       a, b, c, d, e, f, g, h;
   logic [W-1:0]       s0, s1, ch, maj, t1, t2;
   logic               last;
   logic               init_fire;
   logic               kw_fire;

   function automatic logic [W-1:0] rotr(
      input logic [W-1:0] x,
      input int           n
   );
      return (x >> n) | (x << (W - n));
   endfunction

   // Word 7 is a (MSBs of the packed state), word 0 is h.
   assign a = wk_q[7];
   assign b = wk_q[6];
   assign c = wk_q[5];
   assign d = wk_q[4];
   assign e = wk_q[3];
   assign f = wk_q[2];
   assign g = wk_q[1];
   assign h = wk_q[0];

   assign s0  = rotr(a, S0A) ^ rotr(a, S0B) ^ rotr(a, S0C);
   assign s1  = rotr(e, S1A) ^ rotr(e, S1B) ^ rotr(e, S1C);
   assign ch  = (e & f) ^ (~e & g);
   assign maj = (a & b) ^ (a & c) ^ (b & c);
   assign t1  = h + s1 + ch + kw_data;
   assign t2  = s0 + maj;

   always_comb begin
      wk_nxt = {t1 + t2, a, b, c, d + t1, e, f, g};
      for (int i = 0; i < 8; i++) begin
         fb[i] = hs_q[i] + wk_nxt[i];
      end
   end

   assign last      = (cnt_q == CW'(ROUNDS - 1));
   assign init_fire = init_valid && init_ready;
   assign kw_fire   = kw_valid && kw_ready;
   assign out_state = out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_ready = 1'b0;
      kw_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      unique case (state_q)
         IDLE: begin
            init_ready = 1'b1;
            if (init_valid) state_d = ROUND;
         end
         ROUND: begin
            kw_ready = 1'b1;
            busy     = 1'b1;
            if (kw_valid && last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wk_q  <= '0;
         hs_q  <= '0;
         out_q <= '0;
         cnt_q <= '0;
      end else begin
         if (init_fire) begin
            wk_q  <= init_state;
            hs_q  <= init_state;
            cnt_q <= '0;
         end
         if (kw_fire) begin
            wk_q <= wk_nxt;
            // Counter wraps to 0 on the final word so it never reads ROUNDS.
            if (last) begin
               out_q <= fb;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end

endmodule
